rect_draw_engine: RTL and testbench
===================================

Name: rect_draw_engine

Overview:
- Downstream datapath of the paint controller FSM.
- The controller captures two corner points (X,Y then X2,Y2) plus colour and fill mode, then pulses start.
- This block rasterises the rectangle those corners span and emits one pixel write per cycle to the 160x120 VGA adapter (x, y, colour, plot).
- It reports busy/done back to the controller so that FREEDRAW/DRAW can wait for completion.

Parameters:
- X_W, 8, width of x coordinates.
- Y_W, 7, width of y coordinates.
- X_MAX, 159, largest legal x; inputs above it are clamped.
- Y_MAX, 119, largest legal y; inputs above it are clamped.

Ports:
- Clock  input  1  system clock, all state updates on rising edge.
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- abort  input  1  synchronous cancel of an in-progress draw.
- x0  input  X_W  first corner x.
- y0  input  Y_W  first corner y.
- x1  input  X_W  second corner x.
- y1  input  Y_W  second corner y.
- colour_in  input  3  RGB colour latched at start.
- outline  input  1  latched at start; 1 = border only, 0 = filled.
- x_out  output  X_W  pixel x to VGA adapter.
- y_out  output  Y_W  pixel y to VGA adapter.
- colour_out  output  3  pixel colour to VGA adapter.
- plot  output  1  write-enable to VGA adapter.
- busy  output  1  high from SETUP through DONE inclusive.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State goes to IDLE.
  - x_out, y_out, colour_out, plot, busy, done and all internal registers are cleared to 0 immediately, without waiting for a clock edge.
- All outputs are registered.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - busy=0, plot=0, done=0.
  - If start=1, latch x0,y0,x1,y1,colour_in,outline, then go to SETUP.
- SETUP (1 cycle):
  - Clamp each coordinate to X_MAX/Y_MAX.
  - Compute xmin/xmax and ymin/ymax so corner order is irrelevant.
  - Load the scan counters cx=xmin, cy=ymin.
  - busy=1.
  - Go to DRAW.
- DRAW:
  - Each cycle presents x_out=cx, y_out=cy, colour_out=latched colour.
  - Filled mode: plot=1 on every DRAW cycle.
  - Outline mode: plot=1 only when cx∈{xmin,xmax} or cy∈{ymin,ymax}; otherwise plot=0, but the scan still advances.
  - Scan order is row-major. If cx<xmax then cx+1; else cx=xmin and cy+1.
  - When cx==xmax and cy==ymax on the current cycle, go to DONE next.
- DONE (1 cycle):
  - done=1, plot=0, busy=1.
  - Go to IDLE.
- Timing:
  - start sampled at edge T.
  - First pixel is valid in the cycle after SETUP, i.e. 2 edges after T.
  - DRAW lasts exactly W*H cycles, where W=xmax-xmin+1 and H=ymax-ymin+1.
  - done is asserted in cycle 2+W*H after T.
- Degenerate cases:
  - Zero-area corners (x0==x1, y0==y1) give a single pixel.
  - A 1-wide or 1-tall rectangle in outline mode plots every pixel.
- Clamping: x=200 is treated as 159; y=127 is treated as 119.
- start while busy: ignored. There is no queueing, and latched inputs are unaffected.
- Input changes after start: no effect on the draw in progress.
- abort:
  - abort=1 in SETUP or DRAW goes to IDLE at the next edge, with plot=0, busy=0 and no done pulse.
  - abort has priority over the DRAW→DONE transition.
  - abort in IDLE/DONE is ignored.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-draw: state and outputs are cleared immediately; no done pulse; the next start behaves normally.
- Counter arithmetic is unsigned with no wrap: cx never exceeds xmax ≤ X_MAX, and cy never exceeds ymax ≤ Y_MAX.

Test Plan:
- Single pixel: start with (5,7),(5,7), colour 3'b100, filled -> exactly one plot cycle at (5,7) colour 100, 2 edges after start; done 3 edges after start.
- Filled 3x2: corners (10,20),(12,21) -> plot sequence (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), contiguous; done at edge 8; busy high edges 1–8.
- Swapped corners and outline: corners (13,4),(10,2), outline=1 -> 12 DRAW cycles (4x3); plot=1 on 10 of them; the plot=0 cycles are (11,3) and (12,3).
- Clamping: corners (158,118),(255,127), filled -> xmax=159, ymax=119; exactly 4 plots; no x_out>159 or y_out>119 ever.
- Abort and busy-start:
  - Start a 10x10 fill; pulse start again at DRAW cycle 3 -> ignored.
  - Assert abort at DRAW cycle 5 -> next cycle plot=0, busy=0, done never pulses.
  - New start then draws correctly from its own corners.
- Async reset: drop resetn mid-DRAW between clock edges -> plot, busy, x_out, y_out go to 0 before the next edge; state IDLE after resetn releases.

Source files
------------

// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: latches two corners on start, then emits one pixel write per cycle, row-major, to the VGA adapter.
// Latency: first pixel appears 2 edges after start is sampled, and done pulses 2+W*H edges after start.
// Backpressure: none; start is ignored while busy, and abort cancels SETUP/DRAW with no done pulse.
module rect_draw_engine #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic           Clock,
    input  logic           resetn,
    input  logic           start,
    input  logic           abort,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  logic [2:0]     colour_in,
    input  logic           outline,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [2:0]     colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    state_t         state_q, state_d;
    logic [X_W-1:0] x0_q, x1_q, xmin_q, xmax_q, cx_q;
    logic [Y_W-1:0] y0_q, y1_q, ymin_q, ymax_q, cy_q;
    logic [2:0]     colour_q;
    logic           outline_q;

    logic [X_W-1:0] xa, xb, xmin_s, xmax_s;
    logic [Y_W-1:0] ya, yb, ymin_s, ymax_s;
    logic           last_px, border_px;
    logic           plot_d, busy_d, done_d;

    // Clamp and order the latched corners so the scan always runs min to max.
    always_comb begin
        xa     = (x0_q > X_LIM) ? X_LIM : x0_q;
        xb     = (x1_q > X_LIM) ? X_LIM : x1_q;
        ya     = (y0_q > Y_LIM) ? Y_LIM : y0_q;
        yb     = (y1_q > Y_LIM) ? Y_LIM : y1_q;
        xmin_s = (xa < xb) ? xa : xb;
        xmax_s = (xa < xb) ? xb : xa;
        ymin_s = (ya < yb) ? ya : yb;
        ymax_s = (ya < yb) ? yb : ya;
    end

    assign last_px   = (cx_q == xmax_q) && (cy_q == ymax_q);
    assign border_px = (cx_q == xmin_q) || (cx_q == xmax_q) ||
                       (cy_q == ymin_q) || (cy_q == ymax_q);

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output registers follow the current state one edge later; abort clears them at the same edge.
    always_comb begin
        state_d = state_q;
        plot_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = abort ? IDLE : DRAW;
                busy_d  = !abort;
            end
            DRAW: begin
                busy_d = !abort;
                plot_d = !abort && (!outline_q || border_px);
                if (abort) begin
                    state_d = IDLE;
                end else if (last_px) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge resetn) begin
        if (!resetn) begin
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            colour_q   <= '0;
            outline_q  <= 1'b0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                x0_q      <= x0;
                x1_q      <= x1;
                y0_q      <= y0;
                y1_q      <= y1;
                colour_q  <= colour_in;
                outline_q <= outline;
            end
            if (state_q == SETUP) begin
                xmin_q <= xmin_s;
                xmax_q <= xmax_s;
                ymin_q <= ymin_s;
                ymax_q <= ymax_s;
                cx_q   <= xmin_s;
                cy_q   <= ymin_s;
            end
            // Counters hold on the final pixel, so they never step past xmax/ymax.
            if (state_q == DRAW && !abort) begin
                if (cx_q < xmax_q) begin
                    cx_q <= cx_q + X_W'(1);
                end else if (cy_q < ymax_q) begin
                    cx_q <= xmin_q;
                    cy_q <= cy_q + Y_W'(1);
                end
            end
            if (state_q == DRAW) begin
                x_out      <= cx_q;
                y_out      <= cy_q;
                colour_out <= colour_q;
            end
            plot <= plot_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: directed test-plan scenarios plus randomized rectangles,
// each checked cycle by cycle against a nested-loop raster model of the rectangle.
module tb_rect_draw_engine;

    logic       Clock = 1'b0;
    logic       resetn;
    logic       start;
    logic       abort;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour_in;
    logic       outline;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    int checks = 0;
    int errors = 0;

    rect_draw_engine #(.X_W(8), .Y_W(7), .X_MAX(159), .Y_MAX(119)) dut (
        .Clock(Clock), .resetn(resetn), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .colour_in(colour_in), .outline(outline),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 Clock = ~Clock;

    function automatic int clampi(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic next_cycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Present a request for one edge, then scramble the inputs so any re-sampling shows up.
    task automatic launch(input int ax, input int ay, input int bx, input int by,
                          input logic [2:0] col, input logic outl, input logic with_abort);
        @(negedge Clock);
        x0 = 8'(ax); y0 = 7'(ay); x1 = 8'(bx); y1 = 7'(by);
        colour_in = col; outline = outl; start = 1'b1; abort = with_abort;
        @(posedge Clock);
        #1;
        start = 1'b0; abort = 1'b0;
        x0 = 8'($urandom); y0 = 7'($urandom); x1 = 8'($urandom); y1 = 7'($urandom);
        colour_in = 3'($urandom); outline = ~outl;
    endtask

    task automatic check_draw(input string name, input int ax, input int ay, input int bx, input int by,
                              input logic [2:0] col, input logic outl, input logic with_abort,
                              output int nplots);
        int  xl, xh, yl, yh, idx;
        logic exp_plot;
        xl = clampi(ax, 159) < clampi(bx, 159) ? clampi(ax, 159) : clampi(bx, 159);
        xh = clampi(ax, 159) < clampi(bx, 159) ? clampi(bx, 159) : clampi(ax, 159);
        yl = clampi(ay, 119) < clampi(by, 119) ? clampi(ay, 119) : clampi(by, 119);
        yh = clampi(ay, 119) < clampi(by, 119) ? clampi(by, 119) : clampi(ay, 119);
        nplots = 0;
        idx = 0;
        launch(ax, ay, bx, by, col, outl, with_abort);
        next_cycle();
        checks++;
        if ({plot, busy, done} !== 3'b010) begin
            errors++;
            $display("FAIL %s setup: plot/busy/done=%b expected 010", name, {plot, busy, done});
        end
        for (int yy = yl; yy <= yh; yy++) begin
            for (int xx = xl; xx <= xh; xx++) begin
                next_cycle();
                exp_plot = !outl || xx == xl || xx == xh || yy == yl || yy == yh;
                if (plot === 1'b1) nplots++;
                checks++;
                if (plot !== exp_plot || x_out !== 8'(xx) || y_out !== 7'(yy) ||
                    colour_out !== col || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s pixel %0d: got plot=%b x=%0d y=%0d col=%b busy=%b done=%b, expected plot=%b x=%0d y=%0d col=%b busy=1 done=0",
                             name, idx, plot, x_out, y_out, colour_out, busy, done, exp_plot, xx, yy, col);
                end
                idx++;
            end
        end
        next_cycle();
        checks++;
        if ({plot, busy, done} !== 3'b011) begin
            errors++;
            $display("FAIL %s done cycle: plot/busy/done=%b expected 011", name, {plot, busy, done});
        end
        next_cycle();
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL %s after done: plot/busy/done=%b expected 000", name, {plot, busy, done});
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1; start = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour_in = '0; outline = 1'b0;
        #1 resetn = 1'b0;
        #2;
        checks++;
        if ({x_out, y_out, colour_out, plot, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h expected 0", {x_out, y_out, colour_out, plot, busy, done});
        end
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        resetn = 1'b1;
        next_cycle();
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: plot/busy/done=%b expected 000", {plot, busy, done});
        end
    endtask

    task automatic test_single_pixel();
        int n;
        check_draw("single_pixel", 5, 7, 5, 7, 3'b100, 1'b0, 1'b0, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL single_pixel count: got %0d plots expected 1", n); end
    endtask

    task automatic test_filled_3x2();
        int n;
        check_draw("filled_3x2", 10, 20, 12, 21, 3'b010, 1'b0, 1'b0, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL filled_3x2 count: got %0d plots expected 6", n); end
    endtask

    task automatic test_outline_swapped();
        int n;
        check_draw("outline_swapped", 13, 4, 10, 2, 3'b011, 1'b1, 1'b0, n);
        checks++;
        if (n !== 10) begin errors++; $display("FAIL outline_swapped count: got %0d plots expected 10", n); end
    endtask

    task automatic test_clamp();
        int n;
        check_draw("clamp", 158, 118, 255, 127, 3'b111, 1'b0, 1'b0, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL clamp count: got %0d plots expected 4", n); end
    endtask

    task automatic test_start_abort_idle();
        int n;
        check_draw("start_abort_idle", 60, 70, 61, 71, 3'b101, 1'b1, 1'b1, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL start_abort_idle count: got %0d plots expected 4", n); end
    endtask

    task automatic test_abort_setup();
        launch(30, 30, 35, 35, 3'b001, 1'b0, 1'b0);
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({plot, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_setup cycle %0d: plot/busy/done=%b expected 000", k, {plot, busy, done});
            end
            next_cycle();
        end
    endtask

    task automatic test_abort_busy_start();
        int n;
        launch(20, 30, 29, 39, 3'b110, 1'b0, 1'b0);
        next_cycle();
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            checks++;
            if (plot !== 1'b1 || busy !== 1'b1 || x_out !== 8'(20 + j) || y_out !== 7'd30 || colour_out !== 3'b110) begin
                errors++;
                $display("FAIL abort_busy_start pixel %0d: got plot=%b busy=%b x=%0d y=%0d col=%b expected plot=1 busy=1 x=%0d y=30 col=110",
                         j, plot, busy, x_out, y_out, colour_out, 20 + j);
            end
            if (j == 1) begin
                start = 1'b1; x0 = 8'd100; y0 = 7'd100; x1 = 8'd101; y1 = 7'd101; colour_in = 3'b001;
            end else if (j == 2) begin
                start = 1'b0;
            end else if (j == 3) begin
                abort = 1'b1;
            end
        end
        next_cycle();
        abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({plot, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL abort_busy_start post-abort cycle %0d: plot/busy/done=%b expected 000", k, {plot, busy, done});
            end
            next_cycle();
        end
        check_draw("after_abort", 90, 15, 92, 13, 3'b010, 1'b1, 1'b0, n);
        checks++;
        if (n !== 8) begin errors++; $display("FAIL after_abort count: got %0d plots expected 8", n); end
    endtask

    task automatic test_async_reset();
        int n;
        launch(40, 50, 45, 55, 3'b101, 1'b0, 1'b0);
        repeat (3) next_cycle();
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({x_out, y_out, colour_out, plot, busy, done} !== '0) begin
            errors++;
            $display("FAIL async_reset mid-draw: outputs=%h expected 0", {x_out, y_out, colour_out, plot, busy, done});
        end
        @(negedge Clock);
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            checks++;
            if ({plot, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL async_reset idle cycle %0d: plot/busy/done=%b expected 000", k, {plot, busy, done});
            end
        end
        check_draw("after_reset", 7, 3, 9, 3, 3'b011, 1'b0, 1'b0, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL after_reset count: got %0d plots expected 3", n); end
    endtask

    task automatic test_random();
        int n, ax, ay, bx, by, w, h, exp_n;
        logic outl;
        for (int it = 0; it < 12; it++) begin
            ax = int'($urandom_range(0, 255));
            ay = int'($urandom_range(0, 127));
            bx = ax + int'($urandom_range(0, 6)) - 3;
            by = ay + int'($urandom_range(0, 4)) - 2;
            bx = (bx < 0) ? 0 : (bx > 255) ? 255 : bx;
            by = (by < 0) ? 0 : (by > 127) ? 127 : by;
            outl = 1'($urandom);
            w = clampi(ax, 159) - clampi(bx, 159); w = (w < 0) ? 1 - w : w + 1;
            h = clampi(ay, 119) - clampi(by, 119); h = (h < 0) ? 1 - h : h + 1;
            exp_n = (outl && w > 2 && h > 2) ? w * h - (w - 2) * (h - 2) : w * h;
            check_draw("random", ax, ay, bx, by, 3'($urandom), outl, 1'b0, n);
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL random %0d count: got %0d plots expected %0d", it, n, exp_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_filled_3x2();
        test_outline_swapped();
        test_clamp();
        test_start_abort_idle();
        test_abort_setup();
        test_abort_busy_start();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
